// File: rtl/secventiator_cursa_if.sv
// Operator, sensor and driver-gating signals of the race sequencer.
// master drives commands and sensors, slave is the sequencer.
interface secventiator_cursa_if;
    logic        start;
    logic [1:0]  circuit;
    logic        senzor_1;
    logic        senzor_3;
    logic        senzor_5;
    logic        motor_en;
    logic [11:0] factor_dc_max;
    logic [7:0]  count_ture;
    logic        stop;
    logic        cursa_gata;
    logic        eroare_linie;

    modport master (
        output start, circuit, senzor_1, senzor_3, senzor_5,
        input  motor_en, factor_dc_max, count_ture,
        input  stop, cursa_gata, eroare_linie
    );

    modport slave (
        input  start, circuit, senzor_1, senzor_3, senzor_5,
        output motor_en, factor_dc_max, count_ture,
        output stop, cursa_gata, eroare_linie
    );
endinterface

// File: rtl/secventiator_cursa.sv
// Race sequencer: arm/start, duty soft-start, lap counting, brake, line-loss abort.
// Define FRANA_PROGRESIVA_EN for a ramped-down brake instead of a timed hard stop.
module secventiator_cursa #(
    parameter int          DEBOUNCE_CYC = 50000,
    parameter int          RAMP_DIV     = 1000,
    parameter logic [11:0] RAMP_STEP    = 12'h010,
    parameter logic [11:0] DC_MAX       = 12'h999,
    parameter int          LOST_TIMEOUT = 5000000,
    parameter int          BRAKE_CYC    = 25000,
    parameter int          LAPS_C2      = 10
) (
    input logic                 clk,
    input logic                 rst,
    secventiator_cursa_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int VW = $clog2(RAMP_DIV + 1);
    localparam int LW = $clog2(LOST_TIMEOUT + 1);
    localparam int BW = $clog2(BRAKE_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, RAMP, RUN, BRAKE, DONE, LOST
    } state_t;

    state_t          state, state_n;
    logic [11:0]     duty, duty_n;
    logic [VW-1:0]   div_cnt, div_n;
    logic [LW-1:0]   lost_cnt, lost_n;
    logic [BW-1:0]   brk_cnt, brk_n;
    logic [7:0]      cnt, cnt_n;
    logic            gata, gata_n;
    logic            err, err_n;
    logic            motor_q, stop_q;
    logic            run_n, motor_n;
    logic            start_q, start_rise;
    logic [DW-1:0]   deb_cnt;
    logic            mvalid, lap_evt, mark;
    logic            div_last, lap_end;
    logic [12:0]     up_sum;
    logic [11:0]     up_val;

    assign mark       = bus.senzor_1 & bus.senzor_5;
    assign start_rise = bus.start & ~start_q;
    assign div_last   = (div_cnt == VW'(RAMP_DIV - 1));
    assign up_sum     = {1'b0, duty} + {1'b0, RAMP_STEP};
    assign up_val     = (up_sum >= {1'b0, DC_MAX}) ? DC_MAX : up_sum[11:0];

`ifdef FRANA_PROGRESIVA_EN
    logic [11:0] dn_val;
    assign dn_val  = (duty > RAMP_STEP) ? duty - RAMP_STEP : 12'h000;
    assign motor_n = run_n | (state_n == BRAKE);
`else
    assign motor_n = run_n;
`endif
    assign run_n = (state_n == RAMP) | (state_n == RUN);

    always_comb begin
        state_n = state;
        duty_n  = duty;
        div_n   = div_cnt;
        lost_n  = '0;
        brk_n   = '0;
        cnt_n   = cnt;
        gata_n  = gata;
        err_n   = err;
        lap_end = 1'b0;
        if (bus.circuit == 2'b00) begin
            state_n = IDLE;
            cnt_n   = '0;
            duty_n  = '0;
            div_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    duty_n = '0;
                    div_n  = '0;
                    if (start_rise) begin
                        state_n = RAMP;
                        cnt_n   = '0;
                        gata_n  = 1'b0;
                        err_n   = 1'b0;
                    end
                end
                RAMP, RUN: begin
                    lost_n = bus.senzor_3 ? '0 : lost_cnt + LW'(1);
                    if (state == RAMP) begin
                        div_n = div_last ? '0 : div_cnt + VW'(1);
                        if (div_last) begin
                            duty_n = up_val;
                            if (up_val == DC_MAX) state_n = RUN;
                        end
                    end
                    if (lap_evt) begin
                        cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                        lap_end = ((bus.circuit == 2'b01) && (cnt_n == 8'd1)) ||
                                  ((bus.circuit == 2'b10) && (cnt_n == 8'(LAPS_C2)));
                    end
                    // a lap that ends the run outranks a simultaneous line loss
                    if (lap_end) begin
                        state_n = BRAKE;
                        div_n   = '0;
                        lost_n  = '0;
`ifdef FRANA_PROGRESIVA_EN
                        duty_n  = duty;
`else
                        duty_n  = '0;
`endif
                    end else if (!bus.senzor_3 &&
                                 lost_cnt == LW'(LOST_TIMEOUT - 1)) begin
                        state_n = LOST;
                        duty_n  = '0;
                        lost_n  = '0;
                        err_n   = 1'b1;
                    end
                end
                BRAKE: begin
`ifdef FRANA_PROGRESIVA_EN
                    if (duty == '0) begin
                        state_n = DONE;
                        gata_n  = 1'b1;
                    end else begin
                        div_n = div_last ? '0 : div_cnt + VW'(1);
                        if (div_last) duty_n = dn_val;
                    end
`else
                    duty_n = '0;
                    brk_n  = brk_cnt + BW'(1);
                    if (brk_cnt == BW'(BRAKE_CYC - 1)) begin
                        state_n = DONE;
                        gata_n  = 1'b1;
                        brk_n   = '0;
                    end
`endif
                end
                DONE, LOST: begin
                    duty_n = '0;
                    if (start_rise) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            duty     <= '0;
            div_cnt  <= '0;
            lost_cnt <= '0;
            brk_cnt  <= '0;
            cnt      <= '0;
            gata     <= 1'b0;
            err      <= 1'b0;
            motor_q  <= 1'b0;
            stop_q   <= 1'b1;
            start_q  <= 1'b0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            div_cnt  <= div_n;
            lost_cnt <= lost_n;
            brk_cnt  <= brk_n;
            cnt      <= cnt_n;
            gata     <= gata_n;
            err      <= err_n;
            motor_q  <= motor_n;
            stop_q   <= ~run_n;
            start_q  <= bus.start;
        end
    end

    // marker filter: count consecutive samples that disagree with mvalid
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt <= '0;
            mvalid  <= 1'b0;
            lap_evt <= 1'b0;
        end else begin
            lap_evt <= 1'b0;
            if (mark != mvalid) begin
                if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                    mvalid  <= mark;
                    deb_cnt <= '0;
                    lap_evt <= mark;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign bus.motor_en      = motor_q;
    assign bus.stop          = stop_q;
    assign bus.factor_dc_max = duty;
    assign bus.count_ture    = cnt;
    assign bus.cursa_gata    = gata;
    assign bus.eroare_linie  = err;
endmodule

// File: tb/tb_secventiator_cursa.sv
// Bench for secventiator_cursa: per-cycle model comparison plus literal checkpoints.
module tb_secventiator_cursa;
    localparam int          DEB   = 4;
    localparam int          RDIV  = 2;
    localparam logic [11:0] STEP  = 12'h100;
    localparam logic [11:0] DMAX  = 12'h999;
    localparam int          LTO   = 20;
    localparam int          BRK   = 8;
    localparam int          LAPS2 = 3;

    localparam int P_IDLE = 0, P_RAMP = 1, P_RUN = 2;
    localparam int P_BRAKE = 3, P_DONE = 4, P_LOST = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    secventiator_cursa_if bus();

    secventiator_cursa #(
        .DEBOUNCE_CYC(DEB), .RAMP_DIV(RDIV), .RAMP_STEP(STEP),
        .DC_MAX(DMAX), .LOST_TIMEOUT(LTO), .BRAKE_CYC(BRK),
        .LAPS_C2(LAPS2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: phase, elapsed cycles and run lengths
    int ph, t_ph, lost_run, mark_run, cnt, duty;
    bit mvalid, lap_pend, gata, err, start_prev;

    always @(posedge clk) begin : model
        bit lap_now, m, rise, ends;
        if (rst) begin
            ph = P_IDLE; t_ph = 0; lost_run = 0; mark_run = 0;
            cnt = 0; duty = 0; mvalid = 0; lap_pend = 0;
            gata = 0; err = 0; start_prev = 0;
        end else begin
            lap_now  = lap_pend;
            lap_pend = 0;
            m = bus.senzor_1 && bus.senzor_5;
            if (m == mvalid) mark_run = 0;
            else begin
                mark_run++;
                if (mark_run == DEB) begin
                    mvalid = m; mark_run = 0; lap_pend = m;
                end
            end
            rise = bus.start && !start_prev;
            start_prev = bus.start;
            if (bus.circuit == 2'b00) begin
                ph = P_IDLE; cnt = 0; duty = 0;
            end else if (ph == P_IDLE) begin
                if (rise) begin
                    ph = P_RAMP; t_ph = 0; lost_run = 0;
                    cnt = 0; gata = 0; err = 0; duty = 0;
                end
            end else if (ph == P_RAMP || ph == P_RUN) begin
                lost_run = bus.senzor_3 ? 0 : lost_run + 1;
                if (ph == P_RAMP) begin
                    t_ph++;
                    duty = (t_ph / RDIV) * int'(STEP);
                    if (duty >= int'(DMAX)) begin
                        duty = int'(DMAX); ph = P_RUN;
                    end
                end
                ends = 0;
                if (lap_now) begin
                    if (cnt < 255) cnt++;
                    ends = (bus.circuit == 2'b01 && cnt == 1) ||
                           (bus.circuit == 2'b10 && cnt == LAPS2);
                end
                if (ends) begin
                    ph = P_BRAKE; t_ph = 0;
`ifndef FRANA_PROGRESIVA_EN
                    duty = 0;
`endif
                end else if (lost_run == LTO) begin
                    ph = P_LOST; err = 1; duty = 0;
                end
            end else if (ph == P_BRAKE) begin
`ifdef FRANA_PROGRESIVA_EN
                if (duty == 0) begin
                    ph = P_DONE; gata = 1;
                end else begin
                    t_ph++;
                    if (t_ph % RDIV == 0)
                        duty = (duty > int'(STEP)) ? duty - int'(STEP) : 0;
                end
`else
                t_ph++;
                if (t_ph == BRK) begin
                    ph = P_DONE; gata = 1;
                end
`endif
            end else if (rise) begin
                ph = P_IDLE;
            end
        end
    end

    always @(negedge clk) begin
        bit run, mot;
        if (chk_en) begin
            run = (ph == P_RAMP) || (ph == P_RUN);
`ifdef FRANA_PROGRESIVA_EN
            mot = run || (ph == P_BRAKE);
`else
            mot = run;
`endif
            chk("motor_en", 32'(bus.motor_en), 32'(mot));
            chk("stop", 32'(bus.stop), 32'(!run));
            chk("factor_dc_max", 32'(bus.factor_dc_max), 32'(duty));
            chk("count_ture", 32'(bus.count_ture), 32'(cnt));
            chk("cursa_gata", 32'(bus.cursa_gata), 32'(gata));
            chk("eroare_linie", 32'(bus.eroare_linie), 32'(err));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic marker(input int hi, input int lo);
        bus.senzor_1 = 1'b1; bus.senzor_5 = 1'b1;
        cyc(hi);
        bus.senzor_1 = 1'b0; bus.senzor_5 = 1'b0;
        cyc(lo);
    endtask

    task automatic start_edge();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.circuit = 2'b01;
        bus.senzor_1 = 1'b0; bus.senzor_3 = 1'b1; bus.senzor_5 = 1'b0;
        cyc(2);
        chk_en = 1;
        chk("rst motor_en", 32'(bus.motor_en), 0);
        chk("rst stop", 32'(bus.stop), 1);
        chk("rst duty", 32'(bus.factor_dc_max), 0);
        chk("rst count", 32'(bus.count_ture), 0);
        rst = 1'b0;
        cyc(1);

        // soft start to full scale
        start_edge();
        chk("ramp motor_en", 32'(bus.motor_en), 1);
        chk("ramp t0", 32'(bus.factor_dc_max), 0);
        cyc(2);
        chk("ramp 0x100", 32'(bus.factor_dc_max), 32'h100);
        cyc(16);
        chk("ramp 0x900", 32'(bus.factor_dc_max), 32'h900);
        cyc(2);
        chk("ramp 0x999", 32'(bus.factor_dc_max), 32'h999);

        // straight line: one lap ends the run
        bus.senzor_1 = 1'b1; bus.senzor_5 = 1'b1;
        cyc(4);
        chk("m1 pre count", 32'(bus.count_ture), 0);
        cyc(1);
        chk("m1 count", 32'(bus.count_ture), 1);
        chk("m1 stop", 32'(bus.stop), 1);
        chk("m1 motor_en", 32'(bus.motor_en), 0);
        bus.senzor_1 = 1'b0; bus.senzor_5 = 1'b0;
        cyc(7);
        chk("brake hold", 32'(bus.cursa_gata), 0);
        cyc(1);
        chk("done", 32'(bus.cursa_gata), 1);
        cyc(4);

        // curves: glitches ignored, long marker counts once
        bus.circuit = 2'b10;
        start_edge();
        cyc(1);
        start_edge();
        chk("m2 gata cleared", 32'(bus.cursa_gata), 0);
        cyc(20);
        marker(3, 4);
        marker(3, 4);
        chk("glitch count", 32'(bus.count_ture), 0);
        marker(4, 6);
        chk("m2 lap1", 32'(bus.count_ture), 1);
        marker(50, 6);
        chk("m2 lap2", 32'(bus.count_ture), 2);
        marker(4, 6);
        chk("m2 lap3", 32'(bus.count_ture), 3);
        chk("m2 braking", 32'(bus.motor_en), 0);
        cyc(8);
        chk("m2 done", 32'(bus.cursa_gata), 1);

        // line loss: 19 cycles tolerated, 20 aborts
        start_edge();
        cyc(1);
        start_edge();
        cyc(20);
        marker(4, 6);
        bus.senzor_3 = 1'b0;
        cyc(19);
        bus.senzor_3 = 1'b1;
        cyc(1);
        chk("lost19 err", 32'(bus.eroare_linie), 0);
        chk("lost19 motor", 32'(bus.motor_en), 1);
        bus.senzor_3 = 1'b0;
        cyc(19);
        chk("lost pre err", 32'(bus.eroare_linie), 0);
        cyc(1);
        chk("lost err", 32'(bus.eroare_linie), 1);
        chk("lost motor", 32'(bus.motor_en), 0);
        chk("lost count", 32'(bus.count_ture), 1);
        bus.senzor_3 = 1'b1;
        start_edge();
        chk("idle keeps count", 32'(bus.count_ture), 1);
        cyc(1);

        // endurance: saturating lap count
        bus.circuit = 2'b11;
        start_edge();
        for (int i = 0; i < 300; i++) marker(4, 4);
        chk("sat count", 32'(bus.count_ture), 255);
        chk("sat motor", 32'(bus.motor_en), 1);
        chk("sat duty", 32'(bus.factor_dc_max), 32'h999);
        bus.circuit = 2'b00;
        cyc(1);
        chk("c00 count", 32'(bus.count_ture), 0);
        chk("c00 stop", 32'(bus.stop), 1);

        // reset in the middle of the ramp
        bus.circuit = 2'b01;
        start_edge();
        cyc(5);
        chk("mid ramp", 32'(bus.factor_dc_max), 32'h200);
        rst = 1'b1;
        cyc(1);
        chk("rst2 motor", 32'(bus.motor_en), 0);
        chk("rst2 duty", 32'(bus.factor_dc_max), 0);
        chk("rst2 stop", 32'(bus.stop), 1);
        rst = 1'b0;
        cyc(1);

`ifdef FRANA_PROGRESIVA_EN
        start_edge();
        cyc(20);
        marker(4, 1);
        cyc(2);
        chk("soft brake 0x899", 32'(bus.factor_dc_max), 32'h899);
        cyc(25);
        chk("soft brake done", 32'(bus.cursa_gata), 1);
`endif
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/secventiator_cursa.md
Name: secventiator_cursa

Overview:
Sequential race controller that sits in front of the combinational line-following motion logic and the PWM comparators. It arms and starts a run on operator command and soft-starts the motors by ramping the duty-cycle ceiling. It debounces the finish-line marker (senzor_1 and senzor_5 both black) into single lap events, counts laps, ends the run according to the selected circuit mode, and aborts if the centre sensor loses the line for too long. Its outputs gate the motor drivers and clamp the duty-cycle factors sent to the comparators.

Parameters:
DEBOUNCE_CYC, 50000, consecutive cycles the marker must be stable (high to assert, low to re-arm)
RAMP_DIV, 1000, cycles per duty-ramp step
RAMP_STEP, 12'h010, duty increment per step
DC_MAX, 12'h999, full-scale duty ceiling (matches comparator full scale)
LOST_TIMEOUT, 5000000, cycles of senzor_3==0 before line-loss abort
BRAKE_CYC, 25000, brake hold cycles before DONE
LAPS_C2, 10, lap count that ends circuit mode 2'b10

Ports:
clk  input  1  system clock
rst  input  1  reset (already decided): one clock, synchronous, active-high
start  input  1  operator start/acknowledge, level, acted on at its rising edge
circuit  input  2  mode: 00 reset/idle, 01 straight line (1 lap), 10 curves (LAPS_C2 laps), 11 endurance (never ends)
senzor_1  input  1  left marker sensor, 1 = black
senzor_3  input  1  centre sensor, 1 = black (on line)
senzor_5  input  1  right marker sensor, 1 = black
motor_en  output  1  1 = motion logic may drive the motors; 0 = drivers forced to 2'b00
factor_dc_max  output  12  duty ceiling applied to both driver factors
count_ture  output  8  laps completed
stop  output  1  brake light
cursa_gata  output  1  run finished normally
eroare_linie  output  1  run aborted on line loss

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, motor_en=0, factor_dc_max=0, count_ture=0, stop=1, cursa_gata=0, eroare_linie=0, all internal counters 0, marker filter in the not-valid (low) state.
- All outputs are registered: they change one cycle after the causing input.
- Marker filter: m = senzor_1 & senzor_5.
  - marker_valid goes high after m is 1 for DEBOUNCE_CYC consecutive cycles, and low after m is 0 for DEBOUNCE_CYC consecutive cycles.
  - Any opposite sample restarts the count.
  - lap_evt is a 1-cycle pulse on the rising edge of marker_valid.
- States:
  - IDLE: motor_en=0, duty=0, stop=1. On a start rising edge with circuit!=00: clear count_ture, cursa_gata and eroare_linie, then go to RAMP.
  - RAMP: motor_en=1, stop=0.
    - A divider counts 0..RAMP_DIV-1; at RAMP_DIV-1, duty <= min(duty+RAMP_STEP, DC_MAX), with the sum computed in 13 bits.
    - When the new duty equals DC_MAX, go to RUN.
  - RUN: motor_en=1, duty=DC_MAX, stop=0.
  - Lap events in RAMP and RUN: count_ture increments and saturates at 255.
    - Go to BRAKE if the incremented count reaches 1 in mode 01, or LAPS_C2 in mode 10.
    - Mode 11 never ends on laps.
  - Line loss in RAMP and RUN: a lost counter increments while senzor_3==0 and clears when senzor_3==1. Reaching LOST_TIMEOUT sends the block to LOST.
  - Simultaneous lap-end condition and lost timeout: BRAKE wins.
  - BRAKE: motor_en=0, duty=0, stop=1. Hold BRAKE_CYC cycles, then go to DONE.
  - DONE: motor_en=0, stop=1, cursa_gata=1. On a start rising edge, go to IDLE.
  - LOST: motor_en=0, duty=0, stop=1, eroare_linie=1. On a start rising edge, go to IDLE. count_ture is preserved until the next run begins.
- circuit==00 in any state: go to IDLE next cycle and clear count_ture. This is the codebase's lap-reset convention.
- A change of circuit mid-run takes effect at the next lap event.
- Lap events outside RAMP and RUN are ignored.
- start held high does not retrigger; only rising edges act.

Optional Feature:
FRANA_PROGRESIVA_EN
- Defined: in BRAKE, factor_dc_max ramps down by RAMP_STEP every RAMP_DIV cycles, saturating at 0, and motor_en stays 1. DONE is entered the cycle after duty reaches 0. BRAKE_CYC is unused.
- Undefined: immediate duty=0 and motor_en=0, with the BRAKE_CYC hold as above.

Test Plan:
Sim parameters for all scenarios: DEBOUNCE_CYC=4, RAMP_DIV=2, RAMP_STEP=12'h100, LOST_TIMEOUT=20, BRAKE_CYC=8, LAPS_C2=3.
1. Reset then start pulse, circuit=01, senzor_3=1 -> factor_dc_max steps 0x100, 0x200 … 0x900 every 2 cycles, then 0x999; enters RUN after 20 cycles.
2. In RUN (mode 01), m=1 for 4 cycles -> count_ture=1, stop=1, motor_en=0; cursa_gata=1 after 8 brake cycles.
3. Mode 10: m glitches of 3 cycles are ignored; three valid markers, each separated by ≥4 low cycles -> count_ture=3, then BRAKE/DONE. A marker held high 50 cycles counts once.
4. senzor_3=0 for 19 cycles, then 1 -> no abort. senzor_3=0 for 20 cycles -> LOST, eroare_linie=1, count preserved; a start edge returns to IDLE.
5. Mode 11 with 300 markers -> count_ture saturates at 255 and the run continues. Switching circuit to 00 -> IDLE, count_ture=0.
6. rst=1 mid-RAMP -> all outputs at reset values the next cycle. With FRANA_PROGRESIVA_EN, BRAKE from 0x999 ramps 0x899 … 0x099, then 0, then DONE.
